// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle CPU memory-port arbiter.
package cpu_ctrl_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

    // Requester IDs.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // Default memory latency and latency counter width (MEM_LAT is 1..15).
    localparam int unsigned DEFAULT_MEM_LAT = 2;
    localparam int unsigned CNT_W           = 4;

    // Counter preload so completion lands MEM_LAT edges after the memory samples mem_en.
    function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the winner of a contest is whoever was not granted last.
module rr_arb2
    import cpu_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,     // bit 0 = CPU, bit 1 = DMA
    input  logic       update_i,  // commit the current grant as the last grant
    output logic       gnt_id_o
);

    logic last_gnt_q, last_gnt_d;
    logic gnt_id;

    // Grant selection; only meaningful when at least one request is high.
    always_comb begin
        gnt_id = ~last_gnt_q;
        unique case (req_i)
            2'b01:   gnt_id = REQ_CPU;
            2'b10:   gnt_id = REQ_DMA;
            default: gnt_id = ~last_gnt_q;
        endcase
    end

    // Next value of the last-grant register.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (update_i) begin
            last_gnt_d = gnt_id;
        end
    end

    // Last-grant register; resets to DMA so the CPU wins the first contest.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_q <= REQ_DMA;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    assign gnt_id_o = gnt_id;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency synchronous memory port between the CPU control path and a DMA port.
module mem_port_arbiter
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = DEFAULT_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active low

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam logic [CNT_W-1:0] CntLoad = lat_load(MEM_LAT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_en_q, mem_en_d;
    logic              busy_q, busy_d;
    logic              cpu_done_q, cpu_done_d;
    logic              dma_done_q, dma_done_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic              gnt_id;
    logic              arb_update;

    rr_arb2 u_rr_arb2 (
        .clk_i    (clk),
        .rst_ni   (rst),
        .req_i    ({dma_req, cpu_req}),
        .update_i (arb_update),
        .gnt_id_o (gnt_id)
    );

    // Sequencing FSM: next state, capture, latency counter and output register inputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_done_d  = 1'b0;
        dma_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        arb_update  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req || dma_req) begin
                    state_d    = StIssue;
                    arb_update = 1'b1;
                    owner_d    = gnt_id;
                    if (gnt_id == REQ_CPU) begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                cnt_d   = CntLoad;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    // Completion edge: memory read data is valid now.
                    state_d = StIdle;
                    if (owner_q == REQ_CPU) begin
                        cpu_done_d = 1'b1;
                        if (!we_q) begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end else begin
                        dma_done_d = 1'b1;
                        if (!we_q) begin
                            dma_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Strobe and busy are registered from the next state so they align with it.
        mem_en_d = (state_d == StIssue);
        busy_d   = (state_d != StIdle);
    end

    // State, capture and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            owner_q     <= REQ_DMA;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_en_q    <= mem_en_d;
            busy_q      <= busy_d;
            cpu_done_q  <= cpu_done_d;
            dma_done_q  <= dma_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign cpu_done  = cpu_done_q;
    assign dma_done  = dma_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a two-cycle-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_done;
    logic [31:0] dma_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MEM_LAT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_done  (dma_done),
        .dma_rdata (dma_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Memory: samples mem_en at E1, read data valid only for the sample at E3.
    logic [31:0] mem [256];
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [31:0] d1 = '0, d2 = '0;

    always @(posedge clk) begin
        v1 <= mem_en & ~mem_we;
        d1 <= mem[mem_addr[9:2]];
        if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        v2 <= v1;
        d2 <= d1;
    end

    assign mem_rdata = v2 ? d2 : 32'hBAD0_BAD0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h00] = 32'hC0DE_0000;
        mem[8'h01] = 32'hC0DE_0004;
        mem[8'h02] = 32'hD0A0_0008;
        mem[8'h40] = 32'hDEAD_BEEF;

        // Reset state
        step();
        step();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_dma_done", dma_done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        rst = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Single CPU read of 0x100
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        step();  // E0
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 32'h100);
        chk("rd_busy", busy, 1);
        cpu_req = 1'b0;
        step();  // E1
        chk("rd_mem_en_e1", mem_en, 0);
        chk("rd_done_e1", cpu_done, 0);
        step();  // E2
        chk("rd_done_e2", cpu_done, 0);
        step();  // E3
        chk("rd_done_e3", cpu_done, 1);
        chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_dma_done", dma_done, 0);
        step();  // E4
        chk("rd_done_e4", cpu_done, 0);
        chk("rd_busy_e4", busy, 0);
        chk("rd_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

        // DMA write 0x12345678 to 0x40
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h1234_5678;
        step();
        chk("wr_mem_en", mem_en, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 32'h40);
        chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        dma_req = 1'b0;
        step();
        chk("wr_mem_we_hold", mem_we, 1);
        chk("wr_mem_wdata_hold", mem_wdata, 32'h1234_5678);
        step();
        chk("wr_done_e2", dma_done, 0);
        step();
        chk("wr_done_e3", dma_done, 1);
        chk("wr_cpu_done", cpu_done, 0);
        chk("wr_dma_rdata", dma_rdata, 0);
        chk("wr_mem_content", mem[8'h10], 32'h1234_5678);
        step();
        chk("wr_done_e4", dma_done, 0);
        dma_we = 1'b0;

        // Simultaneous requests after reset: CPU, DMA, CPU, DMA
        rst = 1'b0;
        step();
        rst = 1'b1;
        cpu_req = 1'b1; cpu_addr = 32'h0;
        dma_req = 1'b1; dma_addr = 32'h8;
        for (int k = 0; k < 4; k++) begin
            step();  // E0
            chk("rr_mem_en", mem_en, 1);
            chk("rr_mem_addr", mem_addr, (k % 2 == 0) ? 32'h0 : 32'h8);
            step();
            step();
            chk("rr_no_done_e2", cpu_done | dma_done, 0);
            if (k == 3) begin
                cpu_req = 1'b0;
                dma_req = 1'b0;
            end
            step();  // E3
            chk("rr_cpu_done", cpu_done, (k % 2 == 0) ? 1 : 0);
            chk("rr_dma_done", dma_done, (k % 2 == 0) ? 0 : 1);
        end
        chk("rr_cpu_rdata", cpu_rdata, 32'hC0DE_0000);
        chk("rr_dma_rdata", dma_rdata, 32'hD0A0_0008);
        step();
        step();
        chk("rr_idle_busy", busy, 0);
        chk("rr_idle_mem_en", mem_en, 0);

        // Request dropped in WAIT
        cpu_req = 1'b1; cpu_addr = 32'h100;
        step();  // E0
        step();  // E1
        cpu_req = 1'b0;
        step();
        chk("drop_no_done_e2", cpu_done, 0);
        step();
        chk("drop_done", cpu_done, 1);
        chk("drop_rdata", cpu_rdata, 32'hDEAD_BEEF);
        step();
        chk("drop_done_off", cpu_done, 0);
        chk("drop_busy", busy, 0);
        step();
        chk("drop_stay_idle", busy, 0);
        chk("drop_no_mem_en", mem_en, 0);

        // Reset during WAIT; last grant was CPU, so only a reset makes CPU win next
        cpu_req = 1'b1; cpu_addr = 32'h100;
        step();  // E0
        step();  // E1, now in WAIT
        cpu_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_mem_en", mem_en, 0);
        chk("rstw_cpu_done", cpu_done, 0);
        chk("rstw_dma_done", dma_done, 0);
        chk("rstw_cpu_rdata", cpu_rdata, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstw_no_done", cpu_done | dma_done, 0);
        end
        cpu_req = 1'b1; cpu_addr = 32'h0;
        dma_req = 1'b1; dma_addr = 32'h8;
        step();
        chk("rstw_gnt_cpu", mem_addr, 32'h0);
        cpu_req = 1'b0;
        dma_req = 1'b0;
        step();
        step();
        step();
        chk("rstw_cpu_done_after", cpu_done, 1);
        chk("rstw_dma_done_after", dma_done, 0);
        step();

        // Back-to-back CPU reads: mem_en pulses four cycles apart
        cpu_req = 1'b1; cpu_addr = 32'h0;
        step();  // E0
        chk("b2b_en0", mem_en, 1);
        chk("b2b_addr0", mem_addr, 32'h0);
        cpu_addr = 32'h4;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("b2b_en_gap", mem_en, 0);
        end
        chk("b2b_done0", cpu_done, 1);
        chk("b2b_rdata0", cpu_rdata, 32'hC0DE_0000);
        step();  // E4
        chk("b2b_en1", mem_en, 1);
        chk("b2b_addr1", mem_addr, 32'h4);
        cpu_req = 1'b0;
        step();
        step();
        step();
        chk("b2b_done1", cpu_done, 1);
        chk("b2b_rdata1", cpu_rdata, 32'hC0DE_0004);
        step();
        chk("b2b_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the multicycle CPU's single unified memory port between two requesters: the CPU control path (instruction fetch and LW/SW data accesses issued from its memory states) and a DMA/loader port used to preload programs and inspect memory. The block is a small sequencing FSM with round-robin arbitration, a latency counter for a fixed-latency synchronous memory, and a one-cycle completion pulse per requester. The CPU controller holds in its memory states until `cpu_done` pulses.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 2: cycles from memory sampling `mem_en` to `mem_rdata` being valid. Legal range is 1–15.

Ports:
- `clk`  in  1: the single clock for the block.
- `rst`  in  1: asynchronous, active-low reset.
- `cpu_req`  in  1: CPU access request, level.
- `cpu_we`  in  1: 1 = write (SW), 0 = read (fetch/LW).
- `cpu_addr`  in  ADDR_W: CPU address.
- `cpu_wdata`  in  DATA_W: CPU write data.
- `cpu_done`  out  1: one-cycle completion pulse to the CPU.
- `cpu_rdata`  out  DATA_W: read data, held until the next CPU completion.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_done`, `dma_rdata`: identical set of signals for the DMA side.
- `mem_en`  out  1: memory access strobe, one cycle per transaction.
- `mem_we`  out  1: memory write enable, valid with `mem_en`.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: memory read data.
- `busy`  out  1: high in every state other than IDLE.

## Operation
States:
- IDLE: no access in progress.
- ISSUE: `mem_en` is driven high for exactly one cycle.
- WAIT: the latency counter counts down.
- Transitions: IDLE→ISSUE when any `*_req` is sampled high. ISSUE→WAIT always. WAIT→IDLE when the counter reaches 0.

Arbitration and capture:
- Arbitration happens only in IDLE.
- If only one requester is asking, that requester wins.
- If both are asking, the winner is the requester that was not granted last. `last_gnt` resets to DMA, so the CPU wins the first contest.
- On grant, the winner's `we`, `addr` and `wdata` are registered. The `mem_*` outputs come from these registers and stay stable through ISSUE and WAIT.

Counter:
- Loaded with MEM_LAT−1 on ISSUE→WAIT.
- Decrements once per cycle in WAIT.
- The transaction completes at the edge where WAIT is active with the counter at 0.

Completion:
- At the completion edge, reads latch `mem_rdata` into the winner's `*_rdata`. Writes leave `*_rdata` unchanged.
- The winner's `*_done` pulses high for one cycle.
- The state returns to IDLE.

Request handling:
- Requests are level signals. A requester that still has `req` high in the cycle its `done` is asserted gets a new transaction. It is arbitrated normally in IDLE.
- If a requester drops `req` mid-transaction, the transaction still completes and `done` still pulses.

Reset values (all asynchronous):
- State = IDLE, `last_gnt` = DMA, counter = 0.
- `mem_en`, `mem_we`, `busy`, `cpu_done`, `dma_done` = 0.
- `mem_addr`, `mem_wdata`, `cpu_rdata`, `dma_rdata` = 0.
- Reset asserted mid-transaction abandons it. No `done` is issued, and `mem_en` drops immediately.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Edge E0 samples `req` in IDLE. `mem_en` is high during cycle E0–E1.
- The memory samples `mem_en` at E1. Data is valid for sampling at E(1+MEM_LAT).
- `*_done` and `*_rdata` are updated after E(1+MEM_LAT).
- Latency from request sampled to done visible is MEM_LAT+1 edges. Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- Requests arriving during ISSUE/WAIT wait until IDLE. Nothing is queued beyond the level `req`.

## Structure
- Shared package (`cpu_ctrl_pkg`) holds:
  - the arbiter state enum (IDLE/ISSUE/WAIT);
  - requester ID constants (REQ_CPU = 0, REQ_DMA = 1);
  - the default MEM_LAT.
- One sub-module, `rr_arb2`: a two-requester round-robin grant with a `last_gnt` register and an `update` strobe. It is purely arbitration logic and is instantiated once.
- FSM, latency counter, capture registers and output registers live in the top module.

## Test plan
All scenarios use MEM_LAT = 2.
- **Single CPU read:** `cpu_req`=1, `we`=0, `addr`=0x100, memory returns 0xDEADBEEF. Expect `mem_en` for one cycle with `mem_addr`=0x100, then `cpu_done` pulse 3 edges after the request, `cpu_rdata`=0xDEADBEEF. `dma_done` stays 0.
- **DMA write:** `dma_req`=1, `we`=1, `addr`=0x40, `wdata`=0x12345678. Expect `mem_we`=1 with `mem_wdata`=0x12345678 during ISSUE, a `dma_done` pulse, and `dma_rdata` unchanged at 0.
- **Simultaneous requests after reset:** both `req` held high for 4 transactions. Expect grant order CPU, DMA, CPU, DMA, with `done` pulses 4 cycles apart.
- **Request dropped mid-access:** `cpu_req` deasserted in WAIT. Expect the transaction to complete, one `cpu_done` pulse, then IDLE with `busy`=0.
- **Reset mid-operation:** `rst`=0 during WAIT. Expect `mem_en`, `busy` and both `done` signals to be 0 immediately, and no `done` after release. Expect the next contested grant to go to the CPU.
- **Back-to-back CPU:** `cpu_req` held high with `addr`=0x0 then 0x4. Expect `mem_en` pulses exactly 4 cycles apart.
